// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule and round-constant stage
//
// Loads one 512-bit block as 16 sequential 32-bit words (word 0 first), then
// emits W[0..63] four words per group together with K[4g..4g+3]. A 16-entry
// sliding window produces W[16..63] on the fly, four words per handshake.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous abort back to LOAD
//   in_valid/in_ready   message word handshake, in_data = word
//   out_valid/out_ready group handshake toward the compression stage
//   out_w0..out_w3      W[4g..4g+3]
//   out_k0..out_k3      K[4g..4g+3] (0 while loading)
//   out_group           group index g, out_last = (g == 15)
module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w0,
    output logic [31:0] out_w1,
    output logic [31:0] out_w2,
    output logic [31:0] out_w3,
    output logic [31:0] out_k0,
    output logic [31:0] out_k1,
    output logic [31:0] out_k2,
    output logic [31:0] out_k3,
    output logic [3:0]  out_group,
    output logic        out_last
);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  load_cnt, load_cnt_nxt;
    logic [3:0]  grp, grp_nxt;
    logic [31:0] win [16];
    logic        load_fire, run_fire;
    logic [31:0] n0, n1, n2, n3;
    logic [5:0]  k_base;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // win[i] holds W[4g+i]. N2/N3 need W[t+16]/W[t+17] as their sigma1
    // operands, which are N0/N1 from this same step, hence the chain.
    always_comb begin
        n0 = sig1(win[14]) + win[9]  + sig0(win[1]) + win[0];
        n1 = sig1(win[15]) + win[10] + sig0(win[2]) + win[1];
        n2 = sig1(n0)      + win[11] + sig0(win[3]) + win[2];
        n3 = sig1(n1)      + win[12] + sig0(win[4]) + win[3];
    end

    assign load_fire = in_ready && in_valid;
    assign run_fire  = out_valid && out_ready;
    assign k_base    = {grp, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
            grp      <= '0;
        end else begin
            state    <= state_nxt;
            load_cnt <= load_cnt_nxt;
            grp      <= grp_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_cnt_nxt = load_cnt;
        grp_nxt      = grp;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_k0       = '0;
        out_k1       = '0;
        out_k2       = '0;
        out_k3       = '0;
        out_last     = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (load_fire) begin
                    load_cnt_nxt = load_cnt + 4'd1;
                    if (load_cnt == 4'd15) begin
                        state_nxt = ST_RUN;
                        grp_nxt   = '0;
                    end
                end
            end
            ST_RUN: begin
                out_valid = 1'b1;
                out_k0    = K_ROM[k_base];
                out_k1    = K_ROM[k_base + 6'd1];
                out_k2    = K_ROM[k_base + 6'd2];
                out_k3    = K_ROM[k_base + 6'd3];
                out_last  = (grp == 4'd15);
                if (run_fire) begin
                    grp_nxt = grp + 4'd1;
                    if (grp == 4'd15) begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
        // Abort wins over any handshake in the same cycle.
        if (flush) begin
            state_nxt    = ST_LOAD;
            load_cnt_nxt = '0;
            grp_nxt      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (!flush) begin
            if (load_fire) begin
                win[load_cnt] <= in_data;
            end else if (run_fire) begin
                for (int i = 0; i < 12; i++) begin
                    win[i] <= win[i + 4];
                end
                win[12] <= n0;
                win[13] <= n1;
                win[14] <= n2;
                win[15] <= n3;
            end
        end
    end

    assign out_w0    = win[0];
    assign out_w1    = win[1];
    assign out_w2    = win[2];
    assign out_w3    = win[3];
    assign out_group = grp;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - scoreboard bench for sha256_msg_sched
module tb_sha256_msg_sched;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [3:0][31:0] k;
        logic [3:0]       g;
        logic             last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_w0, out_w1, out_w2, out_w3;
    logic [31:0] out_k0, out_k1, out_k2, out_k3;
    logic [3:0]  out_group;
    logic        out_last;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] blk [16];
    bit          abc_mode = 1'b0;

    sha256_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w0    (out_w0),
        .out_w1    (out_w1),
        .out_w2    (out_w2),
        .out_w3    (out_w3),
        .out_k0    (out_k0),
        .out_k1    (out_k1),
        .out_k2    (out_k2),
        .out_k3    (out_k3),
        .out_group (out_group),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic push_expected();
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
        for (int g = 0; g < 16; g++) begin
            for (int j = 0; j < 4; j++) begin
                e.w[j] = w[4*g+j];
                e.k[j] = K_TAB[4*g+j];
            end
            e.g    = 4'(g);
            e.last = (g == 15);
            sb.push_back(e);
        end
    endtask

    task automatic set_abc();
        blk[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) blk[i] = '0;
        blk[15] = 32'h00000018;
    endtask

    // Called at posedge+1. Loads blk[0..n-1]; a complete block is queued.
    task automatic load_block(input int n, input bit bubble);
        for (int i = 0; i < n; i++) begin
            if (bubble) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            chk("load_ready", in_ready, 1);
            chk("load_nvalid", out_valid, 0);
            in_valid = 1'b1;
            in_data  = blk[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (n == 16) begin
            push_expected();
            chk("g0_valid", out_valid, 1);
            chk("g0_group", out_group, 0);
            chk("g0_nready", in_ready, 0);
        end
    endtask

    task automatic run_block(input int stall_g, input int stall_len, input int flush_g);
        int cyc = 0;
        bit done = 1'b0;
        bit hs;
        int stalled = 0;
        logic [3:0] prev_g;
        logic [159:0] snap = '0;
        while (!done && cyc < 200) begin
            flush = 1'b0;
            out_ready = 1'b1;
            if (flush_g >= 0 && out_valid && int'(out_group) == flush_g) begin
                flush = 1'b1;
            end else if (stall_g >= 0 && out_valid && int'(out_group) == stall_g
                         && stalled < stall_len) begin
                if (stalled == 0) snap = {out_w0, out_w1, out_w2, out_w3, out_k0};
                else chk("stall_hold", {out_w0, out_w1, out_w2, out_w3, out_k0}, snap);
                out_ready = 1'b0;
                stalled++;
            end
            hs = out_valid && out_ready && !flush;
            prev_g = out_group;
            @(posedge clk); #1;
            cyc++;
            if (flush) begin
                flush = 1'b0;
                chk("flush_ready", in_ready, 1);
                chk("flush_valid", out_valid, 0);
                chk("flush_group", out_group, 0);
                sb.delete();
                done = 1'b1;
            end else if (hs) begin
                if (prev_g == 4'd15) begin
                    chk("end_valid", out_valid, 0);
                    chk("end_ready", in_ready, 1);
                    chk("sb_drained", sb.size(), 0);
                    done = 1'b1;
                end else begin
                    chk("next_valid", out_valid, 1);
                    chk("next_group", out_group, prev_g + 4'd1);
                end
            end
        end
        if (!done) chk("run_timeout", 0, 1);
        out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("group", out_group, mon_e.g);
                chk("last", out_last, mon_e.last);
                chk("w0", out_w0, mon_e.w[0]);
                chk("w1", out_w1, mon_e.w[1]);
                chk("w2", out_w2, mon_e.w[2]);
                chk("w3", out_w3, mon_e.w[3]);
                chk("k0", out_k0, mon_e.k[0]);
                chk("k1", out_k1, mon_e.k[1]);
                chk("k2", out_k2, mon_e.k[2]);
                chk("k3", out_k3, mon_e.k[3]);
            end
            if (abc_mode) begin
                case (out_group)
                    4'd0: begin
                        chk("abc_g0_w0", out_w0, 32'h61626380);
                        chk("abc_g0_w3", out_w3, 32'h00000000);
                        chk("abc_g0_k0", out_k0, 32'h428a2f98);
                        chk("abc_g0_k1", out_k1, 32'h71374491);
                        chk("abc_g0_k2", out_k2, 32'hb5c0fbcf);
                        chk("abc_g0_k3", out_k3, 32'he9b5dba5);
                    end
                    4'd4: begin
                        chk("abc_g4_w0", out_w0, 32'h61626380);
                        chk("abc_g4_w1", out_w1, 32'h000f0000);
                    end
                    4'd15: begin
                        chk("abc_g15_k3", out_k3, 32'hc67178f2);
                        chk("abc_g15_last", out_last, 1);
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_group", out_group, 0);
        chk("rst_last", out_last, 0);
        chk("rst_w", {out_w0, out_w1, out_w2, out_w3}, 0);
        chk("rst_k", {out_k0, out_k1, out_k2, out_k3}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);

        abc_mode = 1'b1;
        set_abc();
        load_block(16, 1'b0);
        run_block(-1, 0, -1);

        load_block(16, 1'b0);
        run_block(3, 5, -1);

        load_block(16, 1'b1);
        run_block(-1, 0, -1);

        load_block(16, 1'b0);
        run_block(-1, 0, 7);
        load_block(16, 1'b0);
        run_block(-1, 0, -1);

        load_block(9, 1'b0);
        in_valid = 1'b1;
        in_data  = blk[9];
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("arst_w0", out_w0, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_valid", out_valid, 0);
        chk("arst_group", out_group, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        load_block(16, 1'b0);
        run_block(-1, 0, -1);

        abc_mode = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(16, 1'b0);
        run_block(-1, 0, -1);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(16, 1'b0);
        run_block(-1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
